dmem_responder: RTL and testbench
=================================

# dmem_responder

Multi-cycle data memory responder: the memory end of the datapath's load/store interface. It accepts one word read or write per request through a ready/request handshake, inserts a parameterized number of wait states, then returns read data with a one-cycle done pulse. It replaces the zero-latency behavioural data memory, so the core's memory stall logic can be exercised against realistic latency.

## Interface
**Parameters**
- DEPTH, 64: number of 32-bit words stored.
- WAIT, 2: wait states between acceptance and access; 0 to 15.

**Ports**
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- MemReq  in  1  request strobe; sampled only while MemReady=1.
- MemWrite  in  1  1 = write, 0 = read; captured with MemReq.
- Addr  in  32  byte address.
- WriteData  in  32  store data; captured with MemReq.
- MemReady  out  1  responder idle and able to accept a request.
- MemDone  out  1  one-cycle pulse marking access completion; ReadData is valid in this cycle.
- ReadData  out  32  read result; holds its value until the next read completes.
- MemErr  out  1  error flag, valid only with MemDone.

## Operation
- FSM states:
  - IDLE: MemReady=1.
  - BUSY: MemReady=0. The wait counter counts down.
  - RESP: MemDone=1, MemReady=0.
- Transitions:
  - IDLE→BUSY on MemReq. This edge captures Addr, MemWrite and WriteData, and loads cnt=WAIT.
  - BUSY with cnt≠0: decrement cnt.
  - BUSY with cnt==0: perform the access on that edge (write commits, or ReadData loads), then go to RESP.
  - RESP→IDLE unconditionally.
- Input changes while MemReady=0 are ignored. MemReq held high across RESP is not accepted until the cycle after returning to IDLE.
- Word index is Addr[2+log2(DEPTH)-1:2].
- Out of range (Addr[31:2] ≥ DEPTH):
  - A write is dropped; memory is unchanged.
  - A read returns 32'h0.
  - MemErr=0 unless the macro below is enabled.
- Write responses: MemDone still pulses, and ReadData keeps its previous value.
- Storage is not reset; contents are undefined until written.

## Timing
- Reset values: state=IDLE, MemReady=1, MemDone=0, ReadData=32'h0, MemErr=0, cnt=0.
- Latency: with acceptance at edge E0, the access occurs at edge E(WAIT+1). MemDone is high for the cycle between E(WAIT+1) and E(WAIT+2). MemReady returns at E(WAIT+2).
- Throughput: one request per WAIT+3 cycles.
- Reset asserted mid-operation forces IDLE immediately. The in-flight request is discarded; a write that has not reached its access edge never commits.
- A read of an address written by the immediately preceding request returns the new data.

## Configuration
- Macro DMEM_MISALIGN_ERR_EN.
- Defined:
  - Addr[1:0]≠0 sets MemErr=1 during the MemDone cycle.
  - An erroring write is suppressed; an erroring read returns 32'h0.
  - Out-of-range accesses also set MemErr=1.
- Undefined: Addr[1:0] is ignored, and MemErr is tied to 0.

## Structure
- Package dmem_pkg holds:
  - The state enum (IDLE, BUSY, RESP).
  - WORD_W=32.
  - The wait-counter width (4 bits).
- One sub-module, dmem_array: DEPTH×32 storage with synchronous write enable and synchronous registered read, both driven by the FSM on the access edge.
- FSM, counter and capture registers live in dmem_responder.

## Test plan
- WAIT=2. Write 32'hDEADBEEF to 0x10, then read 0x10 → MemDone exactly 3 edges after each accept; ReadData=32'hDEADBEEF; MemReady low for 4 cycles per request.
- WAIT=0. Back-to-back requests with MemReq held high → one acceptance per 3 cycles; no request lost or duplicated.
- Read 0x400 with DEPTH=64 → ReadData=0. A prior write to 0x400 leaves word 0 unchanged. MemErr=1 only with DMEM_MISALIGN_ERR_EN defined.
- With the macro, write to 0x13 → MemErr=1 with MemDone, and word 4 is unchanged. Without the macro, the same write updates word 4 and MemErr=0.
- Assert reset one cycle after accepting a write of 32'h12345678 to 0x20 (WAIT=2) → MemReady=1 immediately, MemDone never pulses, and a subsequent read of 0x20 returns the old contents.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and widths for the multi-cycle data memory responder
package dmem_pkg;
    localparam int WORD_W = 32;
    localparam int CNT_W  = 4;
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
endpackage

// File: rtl/dmem_array.sv
// dmem_array: DEPTH x WORD_W storage, synchronous write, registered read
// Ports: clk, reset (async active-low, clears only the read register),
//        we/wdata (write strobe and data), re (load read register),
//        rd_ok (0 forces a zero read), addr (word index), rdata (held read result)
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic              re,
    input  logic              rd_ok,
    input  logic [AW-1:0]     addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);
    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rdata <= '0;
        else if (re) rdata <= rd_ok ? mem[addr] : '0;
    end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data memory with ready/request handshake and WAIT wait states
// Ports: clk, reset (async active-low), MemReq/MemWrite/Addr/WriteData (request, captured
//        while MemReady=1), MemReady (idle), MemDone (one-cycle completion pulse),
//        ReadData (held read result), MemErr (error, valid with MemDone)
// Build option: DMEM_MISALIGN_ERR_EN flags misaligned and out-of-range accesses on MemErr
// and suppresses misaligned accesses; when undefined Addr[1:0] is ignored and MemErr is 0.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int WAIT  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemReq,
    input  logic              MemWrite,
    input  logic [WORD_W-1:0] Addr,
    input  logic [WORD_W-1:0] WriteData,
    output logic              MemReady,
    output logic              MemDone,
    output logic [WORD_W-1:0] ReadData,
    output logic              MemErr
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t            state, state_d;
    logic [CNT_W-1:0]  cnt;
    logic [WORD_W-1:0] addr_q, wdata_q;
    logic              we_q, access, in_range, bad;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else state <= state_d;
    end

    always_comb begin
        state_d  = IDLE;
        access   = 1'b0;
        MemReady = 1'b0;
        MemDone  = 1'b0;
        state_d  = state == IDLE ? (MemReq ? BUSY : IDLE) :
                   state == BUSY ? (cnt == '0 ? RESP : BUSY) : IDLE;
        access   = state == BUSY && cnt == '0;
        MemReady = state == IDLE;
        MemDone  = state == RESP;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
        end else if (state == IDLE && MemReq) begin
            cnt     <= CNT_W'(WAIT);
            addr_q  <= Addr;
            wdata_q <= WriteData;
            we_q    <= MemWrite;
        end else if (state == BUSY && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign in_range = {2'b00, addr_q[WORD_W-1:2]} < 32'(DEPTH);

`ifdef DMEM_MISALIGN_ERR_EN
    logic err_q;
    assign bad = !in_range || addr_q[1:0] != 2'b00;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) err_q <= 1'b0;
        else if (access) err_q <= bad;
    end
    assign MemErr = state == RESP && err_q;
`else
    logic unused_lsb;
    assign unused_lsb = ^addr_q[1:0];
    assign bad        = !in_range;
    assign MemErr     = 1'b0;
`endif

    dmem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
        .clk   (clk),
        .reset (reset),
        .we    (access && we_q && !bad),
        .re    (access && !we_q),
        .rd_ok (!bad),
        .addr  (addr_q[AW+1:2]),
        .wdata (wdata_q),
        .rdata (ReadData)
    );
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed self-checking bench for dmem_responder (WAIT=2 and WAIT=0 instances)
module tb_dmem_responder;
`ifdef DMEM_MISALIGN_ERR_EN
    localparam logic MIS = 1'b1;
`else
    localparam logic MIS = 1'b0;
`endif
    logic clk = 1'b0, reset = 1'b0;
    logic req, wr, ready, done, err;
    logic [31:0] addr, wd, rdata;
    logic req0, wr0, ready0, done0, err0;
    logic [31:0] addr0, wd0, rdata0;
    logic [31:0] got [4];
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(64), .WAIT(2)) u2 (
        .clk(clk), .reset(reset), .MemReq(req), .MemWrite(wr), .Addr(addr), .WriteData(wd),
        .MemReady(ready), .MemDone(done), .ReadData(rdata), .MemErr(err));

    dmem_responder #(.DEPTH(64), .WAIT(0)) u0 (
        .clk(clk), .reset(reset), .MemReq(req0), .MemWrite(wr0), .Addr(addr0), .WriteData(wd0),
        .MemReady(ready0), .MemDone(done0), .ReadData(rdata0), .MemErr(err0));

    function automatic logic [31:0] pat(input int i);
        return {8'hA5, 8'(i), 16'h5A5A};
    endfunction

    // Issue one request on u2 from an idle state; measures edges to MemDone, cycles with MemReady low
    task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                          output int lat, output int low, output int dn,
                          output logic [31:0] rd, output logic er);
        req = 1'b1; wr = w; addr = a; wd = d;
        @(posedge clk); #1;
        req = 1'b0; wr = ~w; addr = 32'hFFFF_FFFC; wd = ~d;
        lat = -1; low = 0; dn = 0; rd = '0; er = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (ready) break;
            low++;
            if (done) begin lat = n; dn++; rd = rdata; er = err; end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", ready); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
        checks++; if (ready0 !== 1'b1 || done0 !== 1'b0) begin errors++; $display("FAIL reset_u0 got=%b%b exp=10", ready0, done0); end
    endtask

    task automatic test_write_read();
        int lat, low, dn; logic [31:0] rd; logic er;
        do_req(1'b1, 32'h10, 32'hDEADBEEF, lat, low, dn, rd, er);
        checks++; if (lat !== 3) begin errors++; $display("FAIL wr_latency got=%0d exp=3", lat); end
        checks++; if (low !== 4) begin errors++; $display("FAIL wr_ready_low got=%0d exp=4", low); end
        checks++; if (dn !== 1) begin errors++; $display("FAIL wr_done_count got=%0d exp=1", dn); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL wr_rdata_hold got=%h exp=0", rd); end
        do_req(1'b0, 32'h10, 32'h0, lat, low, dn, rd, er);
        checks++; if (lat !== 3) begin errors++; $display("FAIL rd_latency got=%0d exp=3", lat); end
        checks++; if (low !== 4) begin errors++; $display("FAIL rd_ready_low got=%0d exp=4", low); end
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data got=%h exp=deadbeef", rd); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL rd_err got=%b exp=0", er); end
        checks++; if (rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_hold got=%h exp=deadbeef", rdata); end
    endtask

    task automatic test_read_after_write();
        int lat, low, dn; logic [31:0] rd; logic er;
        do_req(1'b1, 32'h14, 32'h0000_1111, lat, low, dn, rd, er);
        do_req(1'b1, 32'h14, 32'hA5A5_0001, lat, low, dn, rd, er);
        do_req(1'b0, 32'h14, 32'h0, lat, low, dn, rd, er);
        checks++; if (rd !== 32'hA5A5_0001) begin errors++; $display("FAIL raw_data got=%h exp=a5a50001", rd); end
    endtask

    task automatic test_out_of_range();
        int lat, low, dn; logic [31:0] rd; logic er;
        do_req(1'b1, 32'h0, 32'h1111_1111, lat, low, dn, rd, er);
        do_req(1'b1, 32'h400, 32'hBAD0_BAD0, lat, low, dn, rd, er);
        checks++; if (dn !== 1) begin errors++; $display("FAIL oob_wr_done got=%0d exp=1", dn); end
        checks++; if (er !== MIS) begin errors++; $display("FAIL oob_wr_err got=%b exp=%b", er, MIS); end
        do_req(1'b0, 32'h400, 32'h0, lat, low, dn, rd, er);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL oob_rd_data got=%h exp=0", rd); end
        checks++; if (er !== MIS) begin errors++; $display("FAIL oob_rd_err got=%b exp=%b", er, MIS); end
        checks++; if (lat !== 3) begin errors++; $display("FAIL oob_rd_latency got=%0d exp=3", lat); end
        do_req(1'b0, 32'h0, 32'h0, lat, low, dn, rd, er);
        checks++; if (rd !== 32'h1111_1111) begin errors++; $display("FAIL oob_word0 got=%h exp=11111111", rd); end
        do_req(1'b1, 32'h8, 32'h77, lat, low, dn, rd, er);
        checks++; if (rd !== 32'h1111_1111) begin errors++; $display("FAIL wr_resp_hold got=%h exp=11111111", rd); end
    endtask

    task automatic test_misalign();
        int lat, low, dn; logic [31:0] rd; logic er;
        logic [31:0] w4;
        do_req(1'b1, 32'h10, 32'h4444_4444, lat, low, dn, rd, er);
        do_req(1'b1, 32'h13, 32'h5555_5555, lat, low, dn, rd, er);
        checks++; if (dn !== 1) begin errors++; $display("FAIL mis_wr_done got=%0d exp=1", dn); end
        checks++; if (er !== MIS) begin errors++; $display("FAIL mis_wr_err got=%b exp=%b", er, MIS); end
        w4 = MIS ? 32'h4444_4444 : 32'h5555_5555;
        do_req(1'b0, 32'h10, 32'h0, lat, low, dn, rd, er);
        checks++; if (rd !== w4) begin errors++; $display("FAIL mis_word4 got=%h exp=%h", rd, w4); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL mis_aligned_err got=%b exp=0", er); end
        do_req(1'b0, 32'h11, 32'h0, lat, low, dn, rd, er);
        checks++; if (rd !== (MIS ? 32'h0 : w4)) begin errors++; $display("FAIL mis_rd_data got=%h exp=%h", rd, MIS ? 32'h0 : w4); end
        checks++; if (er !== MIS) begin errors++; $display("FAIL mis_rd_err got=%b exp=%b", er, MIS); end
    endtask

    task automatic test_reset_mid();
        int lat, low, dn; logic [31:0] rd; logic er;
        int seen;
        do_req(1'b1, 32'h20, 32'hCAFE_0000, lat, low, dn, rd, er);
        req = 1'b1; wr = 1'b1; addr = 32'h20; wd = 32'h1234_5678;
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL mid_reset_ready got=%b exp=1", ready); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL mid_reset_rdata got=%h exp=0", rdata); end
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL mid_reset_done got=%0d exp=0", seen); end
        do_req(1'b0, 32'h20, 32'h0, lat, low, dn, rd, er);
        checks++; if (rd !== 32'hCAFE_0000) begin errors++; $display("FAIL mid_reset_old got=%h exp=cafe0000", rd); end
    endtask

    // Hold MemReq high on the WAIT=0 instance, stepping the request after each acceptance
    task automatic b2b(input logic w, output int acc, output int gaps_bad, output int dn);
        int last;
        logic rdy;
        acc = 0; gaps_bad = 0; dn = 0; last = 0;
        req0 = 1'b1; wr0 = w; addr0 = 32'h0; wd0 = pat(0);
        for (int c = 1; c <= 24; c++) begin
            rdy = ready0 && req0;
            @(posedge clk); #1;
            if (rdy) begin
                if (acc > 0 && c - last != 3) gaps_bad++;
                last = c;
                acc++;
                if (acc == 4) req0 = 1'b0;
                else begin addr0 = 32'(acc * 4); wd0 = pat(acc); end
            end
            if (done0) begin
                if (dn < 4) got[dn] = rdata0;
                dn++;
            end
        end
        req0 = 1'b0;
    endtask

    task automatic test_back_to_back();
        int acc, gaps_bad, dn;
        b2b(1'b1, acc, gaps_bad, dn);
        checks++; if (acc !== 4) begin errors++; $display("FAIL b2b_wr_accepts got=%0d exp=4", acc); end
        checks++; if (gaps_bad !== 0) begin errors++; $display("FAIL b2b_wr_spacing got=%0d exp=0", gaps_bad); end
        checks++; if (dn !== 4) begin errors++; $display("FAIL b2b_wr_dones got=%0d exp=4", dn); end
        b2b(1'b0, acc, gaps_bad, dn);
        checks++; if (acc !== 4) begin errors++; $display("FAIL b2b_rd_accepts got=%0d exp=4", acc); end
        checks++; if (gaps_bad !== 0) begin errors++; $display("FAIL b2b_rd_spacing got=%0d exp=0", gaps_bad); end
        checks++; if (dn !== 4) begin errors++; $display("FAIL b2b_rd_dones got=%0d exp=4", dn); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (got[k] !== pat(k)) begin errors++; $display("FAIL b2b_rd_data%0d got=%h exp=%h", k, got[k], pat(k)); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        req = 1'b0; wr = 1'b0; addr = '0; wd = '0;
        req0 = 1'b0; wr0 = 1'b0; addr0 = '0; wd0 = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_write_read();
        test_read_after_write();
        test_out_of_range();
        test_misalign();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
